// File: rtl/dds_phase_gen.sv
// DDS phase generator: phase accumulator driving a sine-ROM address, with
// glitch-free retune at phase wrap, period-aligned stop and ROM data realignment.
module dds_phase_gen #(
  parameter int PHASE_WIDTH = 32,
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 8,
  parameter int ROM_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [PHASE_WIDTH-1:0] cfg_fword,
  input  logic [ADDR_WIDTH-1:0]  cfg_poffset,
  input  logic                   start,
  input  logic                   stop,
  output logic                   busy,
  output logic [ADDR_WIDTH-1:0]  rom_addr,
  input  logic [DATA_WIDTH-1:0]  rom_data,
  output logic [DATA_WIDTH-1:0]  da_data,
  output logic                   da_valid,
  output logic                   wrap_pulse,
  output logic [1:0]             dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [DATA_WIDTH-1:0] MIDSCALE   = DATA_WIDTH'(1) << (DATA_WIDTH - 1);
  localparam logic [1:0]            DRAIN_LAST = 2'(ROM_LATENCY);

  state_t                 state_q, state_d;
  logic [PHASE_WIDTH-1:0] acc_q, acc_d;
  logic [PHASE_WIDTH-1:0] fword_q, fword_d;
  logic [ADDR_WIDTH-1:0]  poffset_q, poffset_d;
  logic [PHASE_WIDTH-1:0] sh_fword_q, sh_fword_d;
  logic [ADDR_WIDTH-1:0]  sh_poffset_q, sh_poffset_d;
  logic                   pend_q, pend_d;
  logic                   stop_pend_q, stop_pend_d;
  logic [ROM_LATENCY-1:0] vld_sr_q, vld_sr_d;
  logic [1:0]             drain_cnt_q, drain_cnt_d;
  logic [ADDR_WIDTH-1:0]  rom_addr_q, rom_addr_d;
  logic [DATA_WIDTH-1:0]  da_data_q, da_data_d;
  logic                   da_valid_q, da_valid_d;
  logic                   wrap_pulse_q, wrap_pulse_d;

  logic                   cfg_fire;
  logic                   carry;
  logic [PHASE_WIDTH-1:0] acc_sum;
  logic                   vld_in;
  logic                   drain_done;

  // Config handshake: a word transfers on any edge where cfg_valid & cfg_ready;
  // the offerer holds cfg_fword/cfg_poffset stable while cfg_valid is high.
  assign cfg_ready = (state_q == S_IDLE) | ((state_q == S_RUN) & ~pend_q);
  assign cfg_fire  = cfg_valid & cfg_ready;

  assign busy       = (state_q != S_IDLE);
  assign rom_addr   = rom_addr_q;
  assign da_data    = da_data_q;
  assign da_valid   = da_valid_q;
  assign wrap_pulse = wrap_pulse_q;
  assign dbg_state  = state_q;

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    fword_d      = fword_q;
    poffset_d    = poffset_q;
    sh_fword_d   = sh_fword_q;
    sh_poffset_d = sh_poffset_q;
    pend_d       = pend_q;
    stop_pend_d  = stop_pend_q;
    drain_cnt_d  = drain_cnt_q;
    rom_addr_d   = rom_addr_q;
    wrap_pulse_d = 1'b0;
    vld_in       = 1'b0;
    drain_done   = 1'b0;
    da_data_d    = da_data_q;
    da_valid_d   = 1'b0;
    {carry, acc_sum} = {1'b0, acc_q} + {1'b0, fword_q};

    case (state_q)
      S_IDLE: begin
        acc_d = '0;
        if (cfg_fire) begin
          fword_d   = cfg_fword;
          poffset_d = cfg_poffset;
        end
        if (start & ~stop) begin
          state_d    = S_RUN;
          rom_addr_d = cfg_fire ? cfg_poffset : poffset_q;
          vld_in     = 1'b1;
        end
      end
      S_RUN: begin
        acc_d        = acc_sum;
        rom_addr_d   = acc_sum[PHASE_WIDTH-1 -: ADDR_WIDTH] + poffset_q;
        vld_in       = 1'b1;
        wrap_pulse_d = carry;
        if (cfg_fire) begin
          sh_fword_d   = cfg_fword;
          sh_poffset_d = cfg_poffset;
          pend_d       = 1'b1;
        end
        // Retune only at the phase wrap so no period is ever truncated.
        if (carry & pend_q) begin
          fword_d   = sh_fword_q;
          poffset_d = sh_poffset_q;
          pend_d    = 1'b0;
        end
        stop_pend_d = stop_pend_q | stop;
        if ((carry | (fword_q == '0)) & (stop_pend_q | stop)) begin
          state_d     = S_DRAIN;
          drain_cnt_d = 2'd0;
        end
      end
      S_DRAIN: begin
        drain_cnt_d = drain_cnt_q + 2'd1;
        if (drain_cnt_q == DRAIN_LAST) begin
          state_d     = S_IDLE;
          stop_pend_d = 1'b0;
          pend_d      = 1'b0;
          drain_done  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    vld_sr_d = ROM_LATENCY'({vld_sr_q, vld_in});
    if (vld_sr_q[ROM_LATENCY-1]) begin
      da_data_d  = rom_data;
      da_valid_d = 1'b1;
    end
    if (drain_done) da_data_d = MIDSCALE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      acc_q        <= '0;
      fword_q      <= '0;
      poffset_q    <= '0;
      sh_fword_q   <= '0;
      sh_poffset_q <= '0;
      pend_q       <= 1'b0;
      stop_pend_q  <= 1'b0;
      vld_sr_q     <= '0;
      drain_cnt_q  <= 2'd0;
      rom_addr_q   <= '0;
      da_data_q    <= MIDSCALE;
      da_valid_q   <= 1'b0;
      wrap_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      fword_q      <= fword_d;
      poffset_q    <= poffset_d;
      sh_fword_q   <= sh_fword_d;
      sh_poffset_q <= sh_poffset_d;
      pend_q       <= pend_d;
      stop_pend_q  <= stop_pend_d;
      vld_sr_q     <= vld_sr_d;
      drain_cnt_q  <= drain_cnt_d;
      rom_addr_q   <= rom_addr_d;
      da_data_q    <= da_data_d;
      da_valid_q   <= da_valid_d;
      wrap_pulse_q <= wrap_pulse_d;
    end
  end

endmodule

// File: tb/tb_dds_phase_gen.sv
// Bench for dds_phase_gen: table of run scenarios with closed-form address
// expectations, ROM model, and a queue scoreboard for the DAC sample stream.
module tb_dds_phase_gen;

  localparam int L = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [31:0] cfg_fword = '0;
  logic [9:0]  cfg_poffset = '0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        busy;
  logic [9:0]  rom_addr;
  logic [7:0]  rom_data;
  logic [7:0]  da_data;
  logic        da_valid;
  logic        wrap_pulse;
  logic [1:0]  dbg_state;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [31:0] fword;
    logic [9:0]  poff;
    int          step;      // address increment per clock
    int          end_k;     // edge index (start edge = 0) of the last RUN edge
    int          stop_k;    // edge at which stop is sampled
    logic        wrap_end;  // wrap_pulse expected at end_k
    int          cfg_mode;  // 0: cfg before start, 1: cfg with start, 2: no cfg
  } vec_t;

  vec_t vecs[5];

  dds_phase_gen #(
    .PHASE_WIDTH(32), .ADDR_WIDTH(10), .DATA_WIDTH(8), .ROM_LATENCY(L)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_fword(cfg_fword), .cfg_poffset(cfg_poffset),
    .start(start), .stop(stop), .busy(busy),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .da_data(da_data), .da_valid(da_valid),
    .wrap_pulse(wrap_pulse), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_fn(input logic [9:0] a);
    logic [15:0] t;
    t = {6'd0, a} * 16'd37 + 16'd11;
    return t[7:0] ^ a[9:2];
  endfunction

  logic [7:0] rom_reg;
  always @(posedge clk) rom_reg <= rom_fn(rom_addr);
  assign rom_data = (L == 1) ? rom_fn(rom_addr) : rom_reg;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every fresh DAC sample must match the oldest expected ROM word.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && da_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL da_underflow: got da_valid=1 data 0x%0h expected no sample", da_data);
      end else begin
        chk("da_data", {56'd0, da_data}, {56'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic cyc(input string tag, input int k, input int ea, input bit ew,
                     input bit eb, input bit er, input bit ev, input bit push);
    chk($sformatf("%s_addr@%0d", tag, k), 64'(rom_addr), 64'(ea % 1024));
    chk($sformatf("%s_wrap@%0d", tag, k), 64'(wrap_pulse), 64'(ew));
    chk($sformatf("%s_busy@%0d", tag, k), 64'(busy), 64'(eb));
    chk($sformatf("%s_ready@%0d", tag, k), 64'(cfg_ready), 64'(er));
    chk($sformatf("%s_dav@%0d", tag, k), 64'(da_valid), 64'(ev));
    if (push) exp_q.push_back(rom_fn(10'(ea % 1024)));
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_addr"}, 64'(rom_addr), 64'd0);
    chk({tag, "_da"}, 64'(da_data), 64'h80);
    chk({tag, "_dav"}, 64'(da_valid), 64'd0);
    chk({tag, "_wrap"}, 64'(wrap_pulse), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_ready"}, 64'(cfg_ready), 64'd1);
    chk({tag, "_state"}, 64'(dbg_state), 64'd0);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int last_a;
    last_a = 0;
    if (v.cfg_mode == 0) begin
      cfg_valid = 1'b1; cfg_fword = v.fword; cfg_poffset = v.poff;
      @(negedge clk);
      chk({tag, "_cfg_idle_busy"}, 64'(busy), 64'd0);
      cfg_valid = 1'b0;
    end
    for (int k = 0; k <= v.end_k + L + 1; k++) begin
      start = (k == 0);
      stop = (k == v.stop_k);
      cfg_valid = (v.cfg_mode == 1) && (k == 0);
      cfg_fword = v.fword; cfg_poffset = v.poff;
      @(negedge clk);
      if (k <= v.end_k) begin
        last_a = int'(v.poff) + k * v.step;
        cyc(tag, k, last_a, (k == v.end_k) && v.wrap_end, 1'b1, k < v.end_k,
            (k >= L), 1'b1);
      end else begin
        cyc(tag, k, last_a, 1'b0, k < v.end_k + L + 1, k == v.end_k + L + 1,
            k <= v.end_k + L, 1'b0);
      end
    end
    start = 1'b0; stop = 1'b0; cfg_valid = 1'b0;
    chk({tag, "_midscale"}, 64'(da_data), 64'h80);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t pr;
    vecs[0] = '{fword: 32'h0040_0000, poff: 10'd0,    step: 1, end_k: 1024, stop_k: 500, wrap_end: 1'b1, cfg_mode: 0};
    vecs[1] = '{fword: 32'h0040_0000, poff: 10'd256,  step: 1, end_k: 1024, stop_k: 10,  wrap_end: 1'b1, cfg_mode: 1};
    vecs[2] = '{fword: 32'h0100_0000, poff: 10'd1000, step: 4, end_k: 256,  stop_k: 3,   wrap_end: 1'b1, cfg_mode: 0};
    vecs[3] = '{fword: 32'h00C0_0000, poff: 10'd5,    step: 3, end_k: 342,  stop_k: 7,   wrap_end: 1'b1, cfg_mode: 1};
    vecs[4] = '{fword: 32'h0000_0000, poff: 10'd77,   step: 0, end_k: 20,   stop_k: 20,  wrap_end: 1'b0, cfg_mode: 0};

    // Clock/reset
    @(negedge clk);
    check_reset_vals("por");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals("idle");

    for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Live retune: accepted at edge 100, applied at the wrap on edge 1024.
    cfg_valid = 1'b1; cfg_fword = 32'h0040_0000; cfg_poffset = 10'd0;
    @(negedge clk);
    cfg_valid = 1'b0;
    for (int k = 0; k <= 1536 + L + 1; k++) begin
      start = (k == 0);
      stop = (k == 1044);
      if (k == 100) begin
        cfg_valid = 1'b1; cfg_fword = 32'h0080_0000; cfg_poffset = 10'd64;
      end else if (k >= 101 && k <= 200) begin
        cfg_valid = 1'b1; cfg_fword = 32'h0100_0000; cfg_poffset = 10'd3;
      end else begin
        cfg_valid = 1'b0;
      end
      @(negedge clk);
      if (k <= 1024)
        cyc("rt", k, k, k == 1024, 1'b1, (k < 100) || (k == 1024), k >= L, 1'b1);
      else if (k <= 1536)
        cyc("rt", k, 64 + 2 * (k - 1024), k == 1536, 1'b1, k < 1536, 1'b1, 1'b1);
      else
        cyc("rt", k, 64, 1'b0, k < 1536 + L + 1, k == 1536 + L + 1, k <= 1536 + L, 1'b0);
    end
    start = 1'b0; stop = 1'b0; cfg_valid = 1'b0;

    // start & stop together in IDLE: stop wins
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    chk("ss_busy", 64'(busy), 64'd0);
    chk("ss_addr", 64'(rom_addr), 64'd64);
    chk("ss_dav", 64'(da_valid), 64'd0);
    start = 1'b0; stop = 1'b0;
    @(negedge clk);
    chk("ss_busy2", 64'(busy), 64'd0);
    chk("ss_state", 64'(dbg_state), 64'd0);

    // Reset mid-RUN, active config is fword=2^23, poffset=64
    for (int k = 0; k <= 30; k++) begin
      start = (k == 0);
      @(negedge clk);
      cyc("mr", k, 64 + 2 * k, 1'b0, 1'b1, 1'b1, k >= L, 1'b1);
    end
    start = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_vals("midrst");
    exp_q.delete();
    @(negedge clk);
    #1 rst_n = 1'b1;

    // After reset the active config is cleared: fword=0, poffset=0
    pr = '{fword: 32'h0, poff: 10'd0, step: 0, end_k: 5, stop_k: 5, wrap_end: 1'b0, cfg_mode: 2};
    run_vec(pr, "pr");

    @(negedge clk);
    chk("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
